date_month_year_ctr: RTL and testbench

Month/year counter sitting directly downstream of the day-of-month counter. It consumes the day counter's enable and terminal-count flag, and advances the month on each day rollover and the year on each December rollover. It drives the 0-based month code back to the day counter's month-select input. It also provides a button-driven set mode, so the alarm-clock front end can load month and year by hand.

---
 rtl/date_pkg.sv | 34 +++
 rtl/btn_edge.sv | 29 ++
 rtl/date_month_year_ctr.sv | 116 +++++++++++
 tb/tb_date_month_year_ctr.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/date_pkg.sv
// date_pkg: shared definitions for the date counter chain.
//   - state_e      : set-mode FSM states (RUN, SET_MONTH, SET_YEAR)
//   - MO_*         : month codes, 0-based (0 = January)
//   - MO_30        : months that have 30 days
//   - days_in_month: month length for a month code and leap flag
package date_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_MONTH = 2'd1,
        SET_YEAR  = 2'd2
    } state_e;

    localparam logic [6:0] MO_JAN = 7'd0;
    localparam logic [6:0] MO_FEB = 7'd1;
    localparam logic [6:0] MO_DEC = 7'd11;

    // April, June, September, November
    localparam logic [6:0] MO_30 [4] = '{7'd3, 7'd5, 7'd8, 7'd10};

    function automatic logic [4:0] days_in_month(input logic [6:0] month, input logic leap);
        logic [4:0] d;
        d = 5'd31;
        if (month == MO_FEB) begin
            d = leap ? 5'd29 : 5'd28;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (month == MO_30[i]) d = 5'd30;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: registered rising-edge detector for a debounced level button.
//   clk  : system clock
//   rst  : synchronous active-high reset; clears the history
//   in   : button level
//   rise : high for one cycle, the cycle after the button is first seen high
// The history resets to 0, so a button held through reset yields one edge after release.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            in_q   <= in;
            prev_q <= in_q;
        end
    end

    assign rise = in_q & ~prev_q;

endmodule

// File: rtl/date_month_year_ctr.sv
// date_month_year_ctr: month/year counter downstream of the day-of-month counter,
// with a button-driven set mode (RUN -> SET_MONTH -> SET_YEAR -> RUN).
//   clk, rst      : clock, synchronous active-high reset
//   day_en, day_z : day counter enable and last-day flag; a month advances on both high
//   set_btn       : each rising edge steps the set-mode FSM
//   inc_btn       : each rising edge increments the field being set
//   TMo0          : month 0..11, feeds the day counter's month select
//   year          : year offset from 2000, 0..YEAR_MAX
//   days_in_month : length of the current month
//   leap          : current year is a leap year
//   run           : FSM in RUN; gates the day counter enable upstream
//   z             : month is December
// Build option: define DATE_LEAP_YEAR_EN to enable leap years (year % 4 == 0);
// otherwise leap is 0 and February always has 28 days.
module date_month_year_ctr
    import date_pkg::*;
#(
    parameter int unsigned YEAR_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_en,
    input  logic       day_z,
    input  logic       set_btn,
    input  logic       inc_btn,
    output logic [6:0] TMo0,
    output logic [6:0] year,
    output logic [4:0] days_in_month,
    output logic       leap,
    output logic       run,
    output logic       z
);

    localparam logic [6:0] YearMaxW = YEAR_MAX[6:0];

    state_e     state_q, state_d;
    logic [6:0] month_q, month_d;
    logic [6:0] year_q, year_d;
    logic       set_rise, inc_rise;
    logic [6:0] month_inc, year_inc;

    btn_edge u_set_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (set_btn),
        .rise (set_rise)
    );

    btn_edge u_inc_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (inc_btn),
        .rise (inc_rise)
    );

    assign month_inc = (month_q == MO_DEC) ? MO_JAN : month_q + 7'd1;
    assign year_inc  = (year_q >= YearMaxW) ? 7'd0 : year_q + 7'd1;

    always_comb begin
        state_d = state_q;
        month_d = month_q;
        year_d  = year_q;

        // Field update uses the state before any transition taken this cycle.
        unique case (state_q)
            RUN: begin
                if (day_en && day_z) begin
                    month_d = month_inc;
                    if (month_q == MO_DEC) year_d = year_inc;
                end
            end
            SET_MONTH: begin
                if (inc_rise) month_d = month_inc;
            end
            SET_YEAR: begin
                if (inc_rise) year_d = year_inc;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (set_rise) begin
            unique case (state_q)
                RUN:       state_d = SET_MONTH;
                SET_MONTH: state_d = SET_YEAR;
                default:   state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            month_q <= MO_JAN;
            year_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            month_q <= month_d;
            year_q  <= year_d;
        end
    end

`ifdef DATE_LEAP_YEAR_EN
    assign leap = (year_q[1:0] == 2'b00);
`else
    assign leap = 1'b0;
`endif

    assign TMo0          = month_q;
    assign year          = year_q;
    assign days_in_month = date_pkg::days_in_month(month_q, leap);
    assign run           = (state_q == RUN);
    assign z             = (month_q == MO_DEC);

endmodule

// File: tb/tb_date_month_year_ctr.sv
// Directed bench for date_month_year_ctr. Stimulus pushes hand-computed expectations
// into a scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_date_month_year_ctr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       day_en = 1'b0;
    logic       day_z = 1'b0;
    logic       set_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [6:0] TMo0;
    logic [6:0] year;
    logic [4:0] days_in_month;
    logic       leap;
    logic       run;
    logic       z;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string    name;
        int       month;
        int       yr;
        int       run;
        int       z;
        int       dim;
        int       leap;
    } exp_t;

    exp_t sb[$];

    date_month_year_ctr #(.YEAR_MAX(99)) dut (
        .clk           (clk),
        .rst           (rst),
        .day_en        (day_en),
        .day_z         (day_z),
        .set_btn       (set_btn),
        .inc_btn       (inc_btn),
        .TMo0          (TMo0),
        .year          (year),
        .days_in_month (days_in_month),
        .leap          (leap),
        .run           (run),
        .z             (z)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference model for month length and leap flag
    function automatic int m_leap(input int y);
`ifdef DATE_LEAP_YEAR_EN
        return (y % 4 == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int m_dim(input int m, input int y);
        int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 1 && m_leap(y) == 1) return 29;
        return tbl[m];
    endfunction

    task automatic cmp(input string name, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", name, fld, act, req);
        end
    endtask

    // Monitor: the DUT's outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "TMo0", int'(TMo0), e.month);
            cmp(e.name, "year", int'(year), e.yr);
            cmp(e.name, "run", int'(run), e.run);
            cmp(e.name, "z", int'(z), e.z);
            cmp(e.name, "dim", int'(days_in_month), e.dim);
            cmp(e.name, "leap", int'(leap), e.leap);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_state(input string name, input int m, input int y, input int r);
        exp_t e;
        e.name  = name;
        e.month = m;
        e.yr    = y;
        e.run   = r;
        e.z     = (m == 11) ? 1 : 0;
        e.dim   = m_dim(m, y);
        e.leap  = m_leap(y);
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic rollover();
        @(posedge clk); #1;
        day_en = 1'b1;
        day_z  = 1'b1;
        tick(1);
        day_en = 1'b0;
        day_z  = 1'b0;
    endtask

    // Drive the selected buttons high for two cycles (edge then update), then low.
    task automatic press(input logic s, input logic i);
        @(posedge clk); #1;
        set_btn = s;
        inc_btn = i;
        tick(2);
        set_btn = 1'b0;
        inc_btn = 1'b0;
        tick(2);
    endtask

    task automatic press_n_inc(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        expect_state("reset", 0, 0, 1);

        // Feb in year 0, then year 1
        press(1'b1, 1'b0);
        expect_state("enter_set_month", 0, 0, 0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        expect_state("feb_set_year", 1, 0, 0);
        press(1'b1, 1'b0);
        expect_state("feb_y0_run", 1, 0, 1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        expect_state("feb_y1_run", 1, 1, 1);

        // Twelve rollovers from a clean reset
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_state("reset2", 0, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            rollover();
            expect_state($sformatf("roll%0d", i), i % 12, (i == 12) ? 1 : 0, 1);
        end

        // Dec/99 then one rollover wraps both fields
        press(1'b1, 1'b0);
        press_n_inc(11);
        expect_state("set_dec", 11, 1, 0);
        press(1'b1, 1'b0);
        press_n_inc(98);
        expect_state("set_y99", 11, 99, 0);
        press(1'b1, 1'b0);
        expect_state("dec99_run", 11, 99, 1);
        rollover();
        expect_state("wrap_all", 0, 0, 1);

        // Day rollovers ignored in SET_MONTH, then 13 incs
        press(1'b1, 1'b0);
        @(posedge clk); #1;
        day_en = 1'b1;
        day_z  = 1'b1;
        tick(5);
        day_en = 1'b0;
        day_z  = 1'b0;
        expect_state("set_ignores_day", 0, 0, 0);
        press_n_inc(13);
        expect_state("inc13", 1, 0, 0);

        // Simultaneous set+inc in SET_MONTH at month 4
        press_n_inc(3);
        expect_state("month4", 4, 0, 0);
        press(1'b1, 1'b1);
        expect_state("both_edges", 5, 0, 0);
        press(1'b0, 1'b1);
        expect_state("now_set_year", 5, 1, 0);

        // Reset in SET_YEAR with inc held high
        @(posedge clk); #1;
        inc_btn = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        expect_state("rst_in_set", 0, 0, 1);
        tick(1);
        rst = 1'b0;
        tick(4);
        expect_state("held_inc_ignored", 0, 0, 1);
        inc_btn = 1'b0;
        tick(2);
        rollover();
        expect_state("run_after_rst", 1, 0, 1);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
